// File: rtl/mtimer_pkg.sv
// Shared definitions for the Wishbone machine timer: register offsets, CTRL layout, byte-lane merge.
package mtimer_pkg;

    localparam int unsigned MTIME_LO_OFF    = 32'h00;
    localparam int unsigned MTIME_HI_OFF    = 32'h04;
    localparam int unsigned MTIMECMP_LO_OFF = 32'h08;
    localparam int unsigned MTIMECMP_HI_OFF = 32'h0C;
    localparam int unsigned CTRL_OFF        = 32'h10;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_DIV_LSB = 16;
    localparam int unsigned CTRL_DIV_W   = 16;

    typedef struct packed {
        logic [CTRL_DIV_W-1:0] div;
        logic                  en;
    } mtimer_ctrl_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits one tick every DIV+1 enabled cycles.
module mtimer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    input  logic               clear,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_mtimer.sv
// Machine-mode timer with a pipelined Wishbone B4 register slave.
// Define MTIMER_SHADOW_HI_EN for a tear-free MTIME_HI read via a shadow latched on MTIME_LO reads.
module wb_mtimer
    import mtimer_pkg::*;
#(
    parameter int          ADDR_W       = 5,
    parameter int          PRESC_W      = 16,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    output logic              irq_timer_o
);

    localparam logic [CTRL_DIV_W-1:0] DIV_MASK = CTRL_DIV_W'((64'd1 << PRESC_W) - 64'd1);

    logic [63:0]       mtime;
    logic [63:0]       mtime_nxt;
    logic [63:0]       mtimecmp;
    mtimer_ctrl_t      ctrl;
    logic [ADDR_W-1:0] word_adr;
    logic              acc;
    logic              rd;
    logic              wr;
    logic              hit_lo;
    logic              hit_hi;
    logic              hit_cmp_lo;
    logic              hit_cmp_hi;
    logic              hit_ctrl;
    logic              tick;
    logic [31:0]       hi_rd;
    logic [31:0]       rdata;

    assign acc        = wb_cyc_i & wb_stb_i;
    assign rd         = acc & ~wb_we_i;
    assign wr         = acc & wb_we_i & (|wb_sel_i);
    assign word_adr   = wb_adr_i & ~ADDR_W'(3);
    assign hit_lo     = (word_adr == ADDR_W'(MTIME_LO_OFF));
    assign hit_hi     = (word_adr == ADDR_W'(MTIME_HI_OFF));
    assign hit_cmp_lo = (word_adr == ADDR_W'(MTIMECMP_LO_OFF));
    assign hit_cmp_hi = (word_adr == ADDR_W'(MTIMECMP_HI_OFF));
    assign hit_ctrl   = (word_adr == ADDR_W'(CTRL_OFF));
    assign wb_stall_o = 1'b0;

    mtimer_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_presc (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .en    (ctrl.en),
        .div   (ctrl.div[PRESC_W-1:0]),
        .clear (wr && hit_ctrl),
        .tick  (tick)
    );

    // A software write to either half suppresses that cycle's increment entirely, so no carry leaks across.
    always_comb begin
        mtime_nxt = mtime;
        if (wr && (hit_lo || hit_hi)) begin
            if (hit_lo) mtime_nxt[31:0]  = byte_merge(mtime[31:0], wb_dat_i, wb_sel_i);
            if (hit_hi) mtime_nxt[63:32] = byte_merge(mtime[63:32], wb_dat_i, wb_sel_i);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            ctrl     <= '0;
        end else begin
            mtime <= mtime_nxt;
            if (wr && hit_cmp_lo) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], wb_dat_i, wb_sel_i);
            if (wr && hit_cmp_hi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wb_dat_i, wb_sel_i);
            if (wr && hit_ctrl) begin
                if (wb_sel_i[CTRL_EN_BIT/8]) ctrl.en <= wb_dat_i[CTRL_EN_BIT];
                for (int i = 0; i < CTRL_DIV_W/8; i++) begin
                    if (wb_sel_i[CTRL_DIV_LSB/8 + i])
                        ctrl.div[8*i +: 8] <= wb_dat_i[CTRL_DIV_LSB + 8*i +: 8] & DIV_MASK[8*i +: 8];
                end
            end
        end
    end

`ifdef MTIMER_SHADOW_HI_EN
    logic [31:0] shadow_hi;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_hi <= '0;
        end else if (rd && hit_lo) begin
            shadow_hi <= mtime[63:32];
        end
    end

    assign hi_rd = shadow_hi;
`else
    assign hi_rd = mtime[63:32];
`endif

    always_comb begin
        rdata = '0;
        if (hit_lo) begin
            rdata = mtime[31:0];
        end else if (hit_hi) begin
            rdata = hi_rd;
        end else if (hit_cmp_lo) begin
            rdata = mtimecmp[31:0];
        end else if (hit_cmp_hi) begin
            rdata = mtimecmp[63:32];
        end else if (hit_ctrl) begin
            rdata[CTRL_EN_BIT]                 = ctrl.en;
            rdata[CTRL_DIV_LSB +: CTRL_DIV_W]  = ctrl.div;
        end
    end

    // Response stage: ack and data one cycle after acceptance; data is zero outside read acks.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            irq_timer_o <= 1'b0;
        end else begin
            wb_ack_o    <= acc;
            wb_dat_o    <= rd ? rdata : '0;
            irq_timer_o <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed self-checking bench for wb_mtimer with hand-computed expected values.
`timescale 1ns/1ps
module tb_wb_mtimer;

    localparam logic [4:0] A_LO     = 5'h00;
    localparam logic [4:0] A_HI     = 5'h04;
    localparam logic [4:0] A_CMP_LO = 5'h08;
    localparam logic [4:0] A_CMP_HI = 5'h0C;
    localparam logic [4:0] A_CTRL   = 5'h10;
    localparam logic [4:0] A_UNMAP  = 5'h14;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_mtimer #(
        .ADDR_W       (5),
        .PRESC_W      (16),
        .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_w),
        .wb_sel_i    (sel),
        .wb_dat_o    (dat_r),
        .wb_ack_o    (ack),
        .wb_stall_o  (stall),
        .irq_timer_o (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: request presented at a negedge, accepted at the next posedge, ack checked one negedge later.
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rv);
        @(negedge clk);
        check("ack_idle", {31'b0, ack}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(negedge clk);
        check("ack_one_cycle", {31'b0, ack}, 32'd1);
        rv  = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus(1'b1, a, d, s, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, a, 32'h0, 4'h0, v);
        check(tag, v, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_w = '0; sel = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("stall", {31'b0, stall}, 32'd0);
        rstn = 1'b1;

        // Reset values of the register map
        rd_chk("rst_mtime_lo", A_LO, 32'h0);
        rd_chk("rst_mtime_hi", A_HI, 32'h0);
        rd_chk("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        check("rst_irq_after", {31'b0, irq}, 32'd0);

        // Prescaler DIV=3: 40 cycles after enabling -> 10 ticks
        wr(A_CTRL, 32'h0003_0001, 4'hF);
        repeat (39) @(negedge clk);
        rd_chk("presc_div3", A_LO, 32'd10);
        // DIV=0: one tick per cycle
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        rd_chk("div0_a", A_LO, 32'd11);
        rd_chk("div0_b", A_LO, 32'd13);
        wr(A_CTRL, 32'h0, 4'hF);
        rd_chk("stopped", A_LO, 32'd16);

        // Interrupt rise and fall
        wr(A_CMP_HI, 32'h0, 4'hF);
        wr(A_CMP_LO, 32'd20, 4'hF);
        check("irq_below", {31'b0, irq}, 32'd0);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("irq_rise_%0d", k), {31'b0, irq}, (k >= 5) ? 32'd1 : 32'd0);
        end
        wr(A_CMP_LO, 32'hFFFF_FFFF, 4'hF);
        check("irq_hold", {31'b0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'b0, irq}, 32'd0);
        wr(A_CTRL, 32'h0, 4'hF);

        // 64-bit wrap: all-ones minus one, two ticks -> 0
        wr(A_HI, 32'hFFFF_FFFF, 4'hF);
        wr(A_LO, 32'hFFFF_FFFE, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        check("irq_wrap_high", {31'b0, irq}, 32'd1);
        wr(A_CTRL, 32'h0, 4'hF);
        check("irq_wrap_last", {31'b0, irq}, 32'd1);
        @(negedge clk);
        check("irq_wrap_clear", {31'b0, irq}, 32'd0);
        rd_chk("wrap_lo", A_LO, 32'h0);
        rd_chk("wrap_hi", A_HI, 32'h0);

        // Carry from LO into HI: exactly one tick with DIV=1
        wr(A_HI, 32'd5, 4'hF);
        wr(A_LO, 32'hFFFF_FFFF, 4'hF);
        wr(A_CTRL, 32'h0001_0001, 4'hF);
        wr(A_CTRL, 32'h0, 4'hF);
        rd_chk("carry_hi", A_HI, 32'd6);
        rd_chk("carry_lo", A_LO, 32'd0);

        // Byte-lane write to LO while ticking: write wins, no carry into HI that cycle
        wr(A_HI, 32'h0, 4'hF);
        wr(A_LO, 32'hFFFF_FFFE, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        wr(A_LO, 32'hAABB_CCDD, 4'b0010);
        wr(A_CTRL, 32'h0, 4'hF);
        rd_chk("sel_lo", A_LO, 32'hFFFF_CD01);
        rd_chk("sel_hi", A_HI, 32'h0);

        // Byte enables on mtimecmp and CTRL field masking
        wr(A_CMP_LO, 32'h1234_5678, 4'b0000);
        rd_chk("sel0_cmp", A_CMP_LO, 32'hFFFF_FFFF);
        wr(A_CMP_LO, 32'h1234_5678, 4'b0101);
        rd_chk("sel_cmp", A_CMP_LO, 32'hFF34_FF78);
        wr(A_CTRL, 32'hFFFF_FFFE, 4'hF);
        rd_chk("ctrl_mask", A_CTRL, 32'hFFFF_0000);

        // Unmapped offset
        wr(A_UNMAP, 32'hDEAD_BEEF, 4'hF);
        rd_chk("unmapped", A_UNMAP, 32'h0);

        // Three back-to-back reads
        @(negedge clk);
        check("b2b_idle", {31'b0, ack}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CMP_LO;
        @(negedge clk);
        check("b2b_ack0", {31'b0, ack}, 32'd1);
        check("b2b_dat0", dat_r, 32'hFF34_FF78);
        adr = A_CTRL;
        @(negedge clk);
        check("b2b_ack1", {31'b0, ack}, 32'd1);
        check("b2b_dat1", dat_r, 32'hFFFF_0000);
        adr = A_UNMAP;
        @(negedge clk);
        check("b2b_ack2", {31'b0, ack}, 32'd1);
        check("b2b_dat2", dat_r, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("b2b_end", {31'b0, ack}, 32'd0);
        check("b2b_end_dat", dat_r, 32'h0);
        wr(A_CTRL, 32'h0, 4'hF);

        // Tear-free HI read across a carry
        wr(A_HI, 32'd1, 4'hF);
        wr(A_LO, 32'hFFFF_FFFE, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        rd_chk("shadow_lo", A_LO, 32'hFFFF_FFFF);
`ifdef MTIMER_SHADOW_HI_EN
        rd_chk("shadow_hi", A_HI, 32'd1);
`else
        rd_chk("live_hi", A_HI, 32'd2);
`endif
        wr(A_CTRL, 32'h0, 4'hF);

        // Asynchronous reset with an ack pending
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_LO;
        @(posedge clk);
        #1;
        check("ack_pre_rst", {31'b0, ack}, 32'd1);
        rstn = 1'b0;
        #1;
        check("ack_async_rst", {31'b0, ack}, 32'd0);
        check("dat_async_rst", dat_r, 32'h0);
        check("irq_async_rst", {31'b0, irq}, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rd_chk("post_rst_lo", A_LO, 32'h0);
        rd_chk("post_rst_hi", A_HI, 32'h0);
        rd_chk("post_rst_ctrl", A_CTRL, 32'h0);
        rd_chk("post_rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
